// File: rtl/motor_ramp_sequencer_pkg.sv
// Register map, FSM encoding and duty width shared by the motor ramp sequencer files.
`ifndef PERIOD_LENGTH
`define PERIOD_LENGTH 16
`endif

package motor_ramp_sequencer_pkg;

  localparam int PERIOD_LENGTH_DEF = `PERIOD_LENGTH;

  localparam logic [3:0] DIR_BASE    = 4'd0;
  localparam logic [3:0] DUTY_BASE   = 4'd8;
  localparam logic [3:0] PERIOD_ADDR = 4'd14;

  localparam logic [2:0] ST_INIT      = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_PERIOD_WR = 3'd2;
  localparam logic [2:0] ST_SCAN_DUTY = 3'd3;
  localparam logic [2:0] ST_SCAN_DIR  = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

  function automatic logic [3:0] reg_addr(input logic [3:0] base, input logic [2:0] idx);
    return base + {1'b0, idx};
  endfunction

endpackage

// File: rtl/motor_ramp_sequencer_ramp_step_calc.sv
// One slew step of a duty value toward its goal, clamped so it never overshoots or wraps.
module ramp_step_calc #(
  parameter int PERIOD_LENGTH = 16,
  parameter int RAMP_STEP     = 16
) (
  input  logic [PERIOD_LENGTH-1:0] cur_duty,
  input  logic [PERIOD_LENGTH-1:0] tgt_duty,
  input  logic                     force_zero,
  output logic [PERIOD_LENGTH-1:0] next_duty,
  output logic                     changed
);

  localparam logic [PERIOD_LENGTH:0] STEP = (PERIOD_LENGTH + 1)'(RAMP_STEP);

  logic [PERIOD_LENGTH:0] cur_ext;
  logic [PERIOD_LENGTH:0] tgt_ext;
  logic [PERIOD_LENGTH:0] diff;
  logic [PERIOD_LENGTH:0] delta;
  logic [PERIOD_LENGTH:0] next_ext;

  always_comb begin
    cur_ext  = {1'b0, cur_duty};
    tgt_ext  = {1'b0, tgt_duty};
    diff     = (tgt_ext >= cur_ext) ? (tgt_ext - cur_ext) : (cur_ext - tgt_ext);
    delta    = (diff > STEP) ? STEP : diff;
    next_ext = cur_ext;
    if (force_zero) begin
      next_ext = '0;
    end else if (tgt_ext >= cur_ext) begin
      next_ext = cur_ext + delta;
    end else begin
      next_ext = cur_ext - delta;
    end
    next_duty = next_ext[PERIOD_LENGTH-1:0];
    changed   = (next_ext != cur_ext);
  end

endmodule

// File: rtl/motor_ramp_sequencer.sv
// Avalon-MM write master that initialises the motor slave, then slews duty and direction
// registers once per ramp tick with dead time before reversal and an emergency stop.
module motor_ramp_sequencer
  import motor_ramp_sequencer_pkg::*;
#(
  parameter int          NUM_MOTORS    = 6,
  parameter int          PERIOD_LENGTH = PERIOD_LENGTH_DEF,
  parameter int          RAMP_STEP     = 16,
  parameter int          TICK_DIV      = 50000,
  parameter int          DEAD_TICKS    = 4,
  parameter logic [15:0] PERIOD_INIT   = 16'd1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_motor,
  input  logic [1:0]               cmd_dir,
  input  logic [PERIOD_LENGTH-1:0] cmd_duty,
  input  logic                     period_valid,
  input  logic [15:0]              period_value,
  input  logic                     estop,
  output logic                     av_chipselect,
  output logic                     av_write,
  output logic [3:0]               av_addr,
  output logic [31:0]              av_writedata,
  output logic                     busy,
  output logic                     cmd_err
);

  localparam int              TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int              DW        = $clog2(DEAD_TICKS + 2);
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0]   DEAD_MAX  = DW'(DEAD_TICKS);
  localparam logic [2:0]      LAST_IDX  = 3'(NUM_MOTORS - 1);
  localparam logic [3:0]      NM        = 4'(NUM_MOTORS);
  localparam logic [3:0]      INIT_LAST = 4'(2 * NUM_MOTORS);

  logic [2:0]               state_reg;
  logic [2:0]               idx_reg;
  logic [3:0]               init_cnt_reg;
  logic [TW-1:0]            tick_cnt_reg;
  logic                     tick_pending_reg;
  logic                     period_pending_reg;
  logic [15:0]              period_reg;
  logic [1:0]               scan_tgt_dir_reg;

  logic [PERIOD_LENGTH-1:0] cur_duty_reg [NUM_MOTORS];
  logic [1:0]               cur_dir_reg  [NUM_MOTORS];
  logic [PERIOD_LENGTH-1:0] tgt_duty_reg [NUM_MOTORS];
  logic [1:0]               tgt_dir_reg  [NUM_MOTORS];
  logic [DW-1:0]            dead_cnt_reg [NUM_MOTORS];

  logic                     tick;
  logic                     cmd_accept;
  logic                     dir_differs;
  logic [PERIOD_LENGTH-1:0] eff_tgt;
  logic [PERIOD_LENGTH-1:0] next_duty;
  logic                     duty_changed;

  assign tick        = (state_reg != ST_INIT) && (tick_cnt_reg == TICK_LAST);
  assign cmd_ready   = !estop && (state_reg != ST_INIT);
  assign cmd_accept  = cmd_valid && cmd_ready;
  assign busy        = (state_reg != ST_IDLE);
  assign dir_differs = (cur_dir_reg[idx_reg] != tgt_dir_reg[idx_reg]);
  // A pending reversal ramps toward zero regardless of the commanded duty.
  assign eff_tgt     = dir_differs ? '0 : tgt_duty_reg[idx_reg];

  ramp_step_calc #(
    .PERIOD_LENGTH (PERIOD_LENGTH),
    .RAMP_STEP     (RAMP_STEP)
  ) u_ramp (
    .cur_duty   (cur_duty_reg[idx_reg]),
    .tgt_duty   (eff_tgt),
    .force_zero (estop),
    .next_duty  (next_duty),
    .changed    (duty_changed)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_MOTORS; i++) begin
        tgt_dir_reg[i]  <= '0;
        tgt_duty_reg[i] <= '0;
      end
      cmd_err <= 1'b0;
    end else begin
      cmd_err <= cmd_accept && (int'(cmd_motor) >= NUM_MOTORS);
      for (int i = 0; i < NUM_MOTORS; i++) begin
        if (estop) begin
          tgt_dir_reg[i]  <= '0;
          tgt_duty_reg[i] <= '0;
        end else if (cmd_accept && (cmd_motor == 3'(i))) begin
          tgt_dir_reg[i]  <= cmd_dir;
          tgt_duty_reg[i] <= cmd_duty;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_reg       <= '0;
      tick_pending_reg   <= 1'b0;
      period_reg         <= PERIOD_INIT;
      period_pending_reg <= 1'b0;
    end else begin
      if (state_reg != ST_INIT) begin
        tick_cnt_reg <= tick ? '0 : (tick_cnt_reg + TW'(1));
      end
      // IDLE consumes any tick directly, so the pending flag only builds up while scanning.
      tick_pending_reg <= (state_reg != ST_IDLE) && (state_reg != ST_INIT) &&
                          (tick_pending_reg || tick);
      if (period_valid) begin
        period_reg         <= period_value;
        period_pending_reg <= 1'b1;
      end else if (state_reg == ST_PERIOD_WR) begin
        period_pending_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= ST_INIT;
      idx_reg          <= '0;
      init_cnt_reg     <= '0;
      scan_tgt_dir_reg <= '0;
      av_chipselect    <= 1'b0;
      av_write         <= 1'b0;
      av_addr          <= '0;
      av_writedata     <= '0;
      for (int i = 0; i < NUM_MOTORS; i++) begin
        cur_duty_reg[i] <= '0;
        cur_dir_reg[i]  <= '0;
        dead_cnt_reg[i] <= '0;
      end
    end else begin
      av_chipselect <= 1'b0;
      av_write      <= 1'b0;
      av_addr       <= '0;
      av_writedata  <= '0;
      case (state_reg)
        ST_INIT: begin
          av_chipselect <= 1'b1;
          av_write      <= 1'b1;
          if (init_cnt_reg < NM) begin
            av_addr <= reg_addr(DIR_BASE, init_cnt_reg[2:0]);
          end else if (init_cnt_reg < INIT_LAST) begin
            av_addr <= reg_addr(DUTY_BASE, 3'(init_cnt_reg - NM));
          end else begin
            av_addr      <= PERIOD_ADDR;
            av_writedata <= 32'(period_reg);
          end
          if (init_cnt_reg == INIT_LAST) begin
            init_cnt_reg <= '0;
            state_reg    <= ST_IDLE;
          end else begin
            init_cnt_reg <= init_cnt_reg + 4'd1;
          end
        end
        ST_IDLE: begin
          idx_reg <= '0;
          if (tick || tick_pending_reg) begin
            state_reg <= period_pending_reg ? ST_PERIOD_WR : ST_SCAN_DUTY;
          end
        end
        ST_PERIOD_WR: begin
          av_chipselect <= 1'b1;
          av_write      <= 1'b1;
          av_addr       <= PERIOD_ADDR;
          av_writedata  <= 32'(period_reg);
          state_reg     <= ST_SCAN_DUTY;
        end
        ST_SCAN_DUTY: begin
          cur_duty_reg[idx_reg] <= next_duty;
          // Freeze the target direction so a command landing mid-scan waits for the next tick.
          scan_tgt_dir_reg      <= tgt_dir_reg[idx_reg];
          if (duty_changed) begin
            av_chipselect <= 1'b1;
            av_write      <= 1'b1;
            av_addr       <= reg_addr(DUTY_BASE, idx_reg);
            av_writedata  <= 32'(next_duty);
          end
          state_reg <= ST_SCAN_DIR;
        end
        ST_SCAN_DIR: begin
          if (cur_dir_reg[idx_reg] != scan_tgt_dir_reg) begin
            if (cur_duty_reg[idx_reg] == '0) begin
              if (dead_cnt_reg[idx_reg] < DEAD_MAX) begin
                dead_cnt_reg[idx_reg] <= dead_cnt_reg[idx_reg] + DW'(1);
              end else begin
                cur_dir_reg[idx_reg]  <= scan_tgt_dir_reg;
                dead_cnt_reg[idx_reg] <= '0;
                av_chipselect         <= 1'b1;
                av_write              <= 1'b1;
                av_addr               <= reg_addr(DIR_BASE, idx_reg);
                av_writedata          <= {30'd0, scan_tgt_dir_reg};
              end
            end
          end else begin
            dead_cnt_reg[idx_reg] <= '0;
          end
          if (idx_reg == LAST_IDX) begin
            state_reg <= ST_DONE;
          end else begin
            idx_reg   <= idx_reg + 3'd1;
            state_reg <= ST_SCAN_DUTY;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Scoreboarded bench: a per-tick reference model queues expected slave writes, a monitor checks them.
module tb_motor_ramp_sequencer;

  localparam int NM     = 6;
  localparam int STEP   = 16;
  localparam int TDIV   = 40;
  localparam int DEAD   = 4;
  localparam int NTICKS = 150;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_motor;
  logic [1:0]  cmd_dir;
  logic [15:0] cmd_duty;
  logic        period_valid;
  logic [15:0] period_value;
  logic        estop;
  logic        av_chipselect;
  logic        av_write;
  logic [3:0]  av_addr;
  logic [31:0] av_writedata;
  logic        busy;
  logic        cmd_err;

  always #5 clk = ~clk;

  motor_ramp_sequencer #(
    .NUM_MOTORS (NM),
    .RAMP_STEP  (STEP),
    .TICK_DIV   (TDIV),
    .DEAD_TICKS (DEAD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_motor     (cmd_motor),
    .cmd_dir       (cmd_dir),
    .cmd_duty      (cmd_duty),
    .period_valid  (period_valid),
    .period_value  (period_value),
    .estop         (estop),
    .av_chipselect (av_chipselect),
    .av_write      (av_write),
    .av_addr       (av_addr),
    .av_writedata  (av_writedata),
    .busy          (busy),
    .cmd_err       (cmd_err)
  );

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  // Reference state of what the slave should hold and what has been commanded.
  int m_cur_duty [NM];
  int m_cur_dir  [NM];
  int m_tgt_duty [NM];
  int m_tgt_dir  [NM];
  int m_dead     [NM];
  int m_period;
  bit m_period_pend;
  bit m_estop;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int addr, input int data);
    wr_t w;
    w.addr = 4'(addr);
    w.data = 32'(data);
    exp_q.push_back(w);
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Expected bus traffic for one ramp tick.
  task automatic model_scan();
    int d;
    int goal;
    if (m_period_pend) begin
      push(14, m_period);
      m_period_pend = 1'b0;
    end
    for (int i = 0; i < NM; i++) begin
      d = m_cur_duty[i];
      if (m_estop) begin
        d = 0;
      end else begin
        goal = (m_cur_dir[i] == m_tgt_dir[i]) ? m_tgt_duty[i] : 0;
        if (goal > d) d = d + min2(STEP, goal - d);
        else          d = d - min2(STEP, d - goal);
      end
      if (d != m_cur_duty[i]) begin
        push(8 + i, d);
        m_cur_duty[i] = d;
      end
      if (m_cur_dir[i] != m_tgt_dir[i]) begin
        if (d == 0) begin
          if (m_dead[i] < DEAD) begin
            m_dead[i]++;
          end else begin
            m_cur_dir[i] = m_tgt_dir[i];
            m_dead[i]    = 0;
            push(i, m_cur_dir[i]);
          end
        end
      end else begin
        m_dead[i] = 0;
      end
    end
  endtask

  task automatic issue_cmd(input int motor, input int dir, input int duty);
    bit acc;
    cmd_valid = 1'b1;
    cmd_motor = 3'(motor);
    cmd_dir   = 2'(dir);
    cmd_duty  = 16'(duty);
    acc = !m_estop;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    check("cmd_err", 64'(cmd_err), 64'(acc && (motor >= NM)));
    if (acc && motor < NM) begin
      m_tgt_dir[motor]  = dir;
      m_tgt_duty[motor] = duty;
    end
  endtask

  task automatic pulse_period(input int value);
    period_valid = 1'b1;
    period_value = 16'(value);
    @(negedge clk);
    period_valid = 1'b0;
    m_period      = value;
    m_period_pend = 1'b1;
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string name, output bit ok);
    int n = 0;
    while (busy !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (busy === lvl);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s: got busy=%0b expected %0b within %0d cycles", name, busy, lvl, budget);
    end
  endtask

  task automatic apply_window(input int t);
    bit new_estop;
    int ncmd;
    @(negedge clk);
    new_estop = m_estop;
    if (t == 45)      new_estop = 1'b1;
    else if (t == 48) new_estop = 1'b0;
    else if (t >= 55 && $urandom_range(0, 19) == 0) new_estop = !m_estop;
    estop   = new_estop;
    m_estop = new_estop;
    if (m_estop) begin
      for (int i = 0; i < NM; i++) begin
        m_tgt_dir[i]  = 0;
        m_tgt_duty[i] = 0;
      end
    end
    #1;
    check("cmd_ready", 64'(cmd_ready), 64'(!m_estop));
    case (t)
      0:  issue_cmd(2, 1, 40);
      10: issue_cmd(2, 2, 40);
      20: issue_cmd(0, 1, 200);
      47: issue_cmd(1, 1, 50);
      49: issue_cmd(0, 1, 64);
      50: begin
        pulse_period(500);
        pulse_period(600);
      end
      52: issue_cmd(7, 3, 99);
      default: begin
        if (t >= 55) begin
          ncmd = $urandom_range(0, 2);
          for (int c = 0; c < ncmd; c++) begin
            issue_cmd(($urandom_range(0, 9) == 0) ? $urandom_range(6, 7) : $urandom_range(0, NM - 1),
                      $urandom_range(0, 3), $urandom_range(0, 160));
          end
          if ($urandom_range(0, 6) == 0) begin
            pulse_period($urandom_range(100, 2000));
            if ($urandom_range(0, 1) == 1) pulse_period($urandom_range(100, 2000));
          end
        end
      end
    endcase
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && (av_write || av_chipselect)) begin
        total++;
        if (!(av_write && av_chipselect)) begin
          bad++;
          $display("FAIL av_strobe: got cs=%0b wr=%0b expected both 1", av_chipselect, av_write);
        end else if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: got addr=%0d data=%0d expected no write", av_addr, av_writedata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (av_addr !== e.addr || av_writedata !== e.data) begin
            bad++;
            $display("FAIL av_write: got addr=%0d data=%0d expected addr=%0d data=%0d",
                     av_addr, av_writedata, e.addr, e.data);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    reset        = 1'b0;
    cmd_valid    = 1'b0;
    cmd_motor    = '0;
    cmd_dir      = '0;
    cmd_duty     = '0;
    period_valid = 1'b0;
    period_value = '0;
    estop        = 1'b0;
    for (int i = 0; i < NM; i++) begin
      m_cur_duty[i] = 0;
      m_cur_dir[i]  = 0;
      m_tgt_duty[i] = 0;
      m_tgt_dir[i]  = 0;
      m_dead[i]     = 0;
    end
    m_period      = 1000;
    m_period_pend = 1'b0;
    m_estop       = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_cs", 64'(av_chipselect), 64'd0);
    check("rst_write", 64'(av_write), 64'd0);
    check("rst_addr", 64'(av_addr), 64'd0);
    check("rst_data", 64'(av_writedata), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_cmd_err", 64'(cmd_err), 64'd0);

    for (int i = 0; i < NM; i++) push(i, 0);
    for (int i = 0; i < NM; i++) push(8 + i, 0);
    push(14, 1000);
    reset = 1'b1;

    wait_busy(1'b0, 100, "init_done", ok);
    @(negedge clk);
    #1;
    check("init_drained", 64'(exp_q.size()), 64'd0);

    for (int t = 0; t < NTICKS && ok; t++) begin
      apply_window(t);
      model_scan();
      wait_busy(1'b1, 3 * TDIV, "scan_start", ok);
      if (ok) wait_busy(1'b0, 60, "scan_end", ok);
      if (ok) begin
        @(negedge clk);
        #1;
        check("scan_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
